// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: mode codes, FSM states and the queued command record.
package alu_pkg;

  localparam int unsigned ALU_W = 4;
  localparam int unsigned MOD_W = 3;

  localparam logic [MOD_W-1:0] ALU_ADD = 3'b000;
  localparam logic [MOD_W-1:0] ALU_SUB = 3'b001;
  localparam logic [MOD_W-1:0] ALU_NEG = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [MOD_W-1:0] mod;
    logic             use_acc;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with registered count; ready/empty are flops so push acceptance never depends on pop.
module cmd_fifo #(
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head_c,
  output logic          ready,
  output logic          empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign head_c  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CW'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      ready <= (count_nxt != CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_cmd_seq.sv
// Sequential front end for the 4-bit ALU: queues commands, drives ALU operands from registers,
// captures result/flags one cycle later and offers them downstream; keeps an accumulator.
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = ALU_W,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_mod,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_mod,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_c,
  input  logic             alu_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_c,
  output logic             res_ovf,
  output logic [WIDTH-1:0] acc
);

  state_t state;
  cmd_t   cmd_in;
  cmd_t   head_c;
  logic   fifo_empty;
  logic   pop_c;

  assign cmd_in = {cmd_a, cmd_b, cmd_mod, cmd_use_acc};

  // Pop from IDLE, or straight from DONE when the current result is taken.
  assign pop_c = !fifo_empty && ((state == IDLE) || ((state == DONE) && res_ready));

  cmd_fifo #(
    .DW    ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (cmd_valid),
    .pop    (pop_c),
    .din    (cmd_in),
    .head_c (head_c),
    .ready  (cmd_ready),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_mod   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_c     <= 1'b0;
      res_ovf   <= 1'b0;
      acc       <= '0;
    end else begin
      // acc was written at least one edge before any pop can read it.
      if (pop_c) begin
        alu_a   <= head_c.use_acc ? acc : head_c.a;
        alu_b   <= head_c.b;
        alu_mod <= head_c.mod;
      end
      case (state)
        IDLE: begin
          if (pop_c) state <= EXEC;
        end
        EXEC: begin
          res_data  <= alu_result;
          acc       <= alu_result;
          res_valid <= 1'b1;
          // NEG leaves the ALU flags undefined, so they are reported as zero.
          if (alu_mod == ALU_NEG) begin
            res_zero <= 1'b0;
            res_c    <= 1'b0;
            res_ovf  <= 1'b0;
          end else begin
            res_zero <= alu_zero;
            res_c    <= alu_c;
            res_ovf  <= alu_ovf;
          end
          state <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= pop_c ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq: a behavioural ALU sits beside the DUT, directed vectors
// and hand sequences cover latency, backpressure and reset, then random traffic runs against a scoreboard.
module tb_alu_cmd_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_mod;
  logic       cmd_use_acc;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_mod;
  logic [3:0] alu_result;
  logic       alu_zero;
  logic       alu_c;
  logic       alu_ovf;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_zero;
  logic       res_c;
  logic       res_ovf;
  logic [3:0] acc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_seq dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_mod     (cmd_mod),
    .cmd_use_acc (cmd_use_acc),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_mod     (alu_mod),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .alu_c       (alu_c),
    .alu_ovf     (alu_ovf),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_zero    (res_zero),
    .res_c       (res_c),
    .res_ovf     (res_ovf),
    .acc         (acc)
  );

  typedef struct packed {
    logic [3:0] res;
    logic       z;
    logic       c;
    logic       v;
  } alu_out_t;

  // External ALU behaviour; NEG drives junk flags since they are undefined there.
  function automatic alu_out_t alu_ext(input logic [3:0] a, input logic [3:0] b, input logic [2:0] mod);
    alu_out_t o;
    int sa, sb, s;
    o  = '0;
    sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
    case (mod)
      ALU_ADD: begin
        s     = int'(a) + int'(b);
        o.res = 4'(s);
        o.c   = (s > 15);
        o.v   = ((sa + sb) > 7) || ((sa + sb) < -8);
        o.z   = (o.res == 4'd0);
      end
      ALU_SUB: begin
        s     = int'(a) - int'(b);
        o.res = 4'(s);
        o.c   = (a >= b);
        o.v   = ((sa - sb) > 7) || ((sa - sb) < -8);
        o.z   = (o.res == 4'd0);
      end
      ALU_NEG: begin
        o.res = (a >= 4'd8) ? 4'(23 - int'(a)) : a;
        o.z   = 1'b1;
        o.c   = 1'b1;
        o.v   = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic alu_out_t expect_of(input logic [3:0] a, input logic [3:0] b, input logic [2:0] mod);
    alu_out_t o;
    o = alu_ext(a, b, mod);
    if (mod == ALU_NEG) begin
      o.z = 1'b0;
      o.c = 1'b0;
      o.v = 1'b0;
    end
    return o;
  endfunction

  alu_out_t ao;
  assign ao         = alu_ext(alu_a, alu_b, alu_mod);
  assign alu_result = ao.res;
  assign alu_zero   = ao.z;
  assign alu_c      = ao.c;
  assign alu_ovf    = ao.v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] mod;
    logic       use_acc;
    logic [3:0] d;
    logic       z;
    logic       c;
    logic       v;
    logic [3:0] acc;
  } vec_t;

  vec_t vt[13];

  // Scoreboard state for the random phase
  alu_out_t   exp_q[$];
  logic [3:0] model_acc;
  logic       prev_stall;
  logic [6:0] prev_res;

  task automatic score_step();
    alu_out_t   e;
    logic [3:0] a_eff;
    if (prev_stall) begin
      check("stall_valid", 32'(res_valid), 32'd1);
      check("stall_hold", 32'({res_data, res_zero, res_c, res_ovf}), 32'(prev_res));
    end
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", res_data);
      end else begin
        e = exp_q.pop_front();
        check("rnd_data", 32'(res_data), 32'(e.res));
        check("rnd_flags", 32'({res_zero, res_c, res_ovf}), 32'({e.z, e.c, e.v}));
        check("rnd_acc", 32'(acc), 32'(e.res));
      end
    end
    if (cmd_valid && cmd_ready) begin
      a_eff     = cmd_use_acc ? model_acc : cmd_a;
      e         = expect_of(a_eff, cmd_b, cmd_mod);
      model_acc = e.res;
      exp_q.push_back(e);
    end
    prev_stall = res_valid && !res_ready;
    prev_res   = {res_data, res_zero, res_c, res_ovf};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         n;
    logic       took[4];
    logic [3:0] seen[$];
    int         at[$];
    logic       saw_res;
    logic [3:0] bp_a[4];
    logic [3:0] bp_b[4];
    logic [2:0] bp_m[4];
    logic [3:0] bp_exp[3];
    int         r;

    vt[0]  = '{4'h3, 4'h5, ALU_ADD, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, 4'h8};
    vt[1]  = '{4'h5, 4'h5, ALU_SUB, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0};
    vt[2]  = '{4'hA, 4'h0, ALU_NEG, 1'b0, 4'hD, 1'b0, 1'b0, 1'b0, 4'hD};
    vt[3]  = '{4'h3, 4'h0, ALU_NEG, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 4'h3};
    vt[4]  = '{4'h9, 4'h9, 3'b111,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
    vt[5]  = '{4'h7, 4'h1, ALU_ADD, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, 4'h8};
    vt[6]  = '{4'h5, 4'h8, ALU_ADD, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0};
    vt[7]  = '{4'h2, 4'h3, ALU_SUB, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'hF};
    vt[8]  = '{4'h0, 4'h1, ALU_SUB, 1'b1, 4'hE, 1'b0, 1'b1, 1'b0, 4'hE};
    vt[9]  = '{4'h4, 4'h4, ALU_ADD, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, 4'h8};
    vt[10] = '{4'h8, 4'h1, ALU_SUB, 1'b0, 4'h7, 1'b0, 1'b1, 1'b1, 4'h7};
    vt[11] = '{4'h8, 4'h0, ALU_NEG, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'hF};
    vt[12] = '{4'hF, 4'hF, 3'b011,  1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};

    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_a       = '0;
    cmd_b       = '0;
    cmd_mod     = '0;
    cmd_use_acc = 1'b0;
    res_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res", 32'({res_data, res_zero, res_c, res_ovf}), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b, alu_mod}), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors, one command at a time with res_ready high
    for (int i = 0; i < 13; i++) begin
      check("vec_cmd_ready", 32'(cmd_ready), 32'd1);
      cmd_valid   = 1'b1;
      cmd_a       = vt[i].a;
      cmd_b       = vt[i].b;
      cmd_mod     = vt[i].mod;
      cmd_use_acc = vt[i].use_acc;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      n = 0;
      while (n < 10) begin
        @(posedge clk);
        #1;
        n++;
        if (res_valid) break;
      end
      check("vec_latency", 32'(n), 32'd2);
      check("vec_data", 32'(res_data), 32'(vt[i].d));
      check("vec_zero", 32'(res_zero), 32'(vt[i].z));
      check("vec_c", 32'(res_c), 32'(vt[i].c));
      check("vec_ovf", 32'(res_ovf), 32'(vt[i].v));
      check("vec_acc", 32'(acc), 32'(vt[i].acc));
      @(posedge clk);
      #1;
      check("vec_consumed", 32'(res_valid), 32'd0);
    end

    // Backpressure: four back-to-back commands while the consumer stalls
    bp_a = '{4'h1, 4'h2, 4'h9, 4'h5};
    bp_b = '{4'h1, 4'h2, 4'h3, 4'h5};
    bp_m = '{ALU_ADD, ALU_ADD, ALU_SUB, ALU_ADD};
    bp_exp = '{4'h2, 4'h4, 4'h6};
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid   = 1'b1;
      cmd_a       = bp_a[i];
      cmd_b       = bp_b[i];
      cmd_mod     = bp_m[i];
      cmd_use_acc = 1'b0;
      took[i]     = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("bp_take0", 32'(took[0]), 32'd1);
    check("bp_take1", 32'(took[1]), 32'd1);
    check("bp_take2", 32'(took[2]), 32'd1);
    check("bp_refuse3", 32'(took[3]), 32'd0);
    check("bp_full", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", 32'(res_valid), 32'd1);
      check("bp_hold_data", 32'({res_data, res_zero, res_c, res_ovf}), 32'({4'h2, 3'b000}));
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    seen.delete();
    at.delete();
    if (res_valid) begin
      seen.push_back(res_data);
      at.push_back(0);
    end
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        seen.push_back(res_data);
        at.push_back(cyc);
      end
    end
    check("bp_count", 32'(seen.size()), 32'd3);
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      check("bp_order", 32'(seen[i]), 32'(bp_exp[i]));
      check("bp_spacing", 32'(at[i]), 32'(2 * i));
    end
    check("bp_acc", 32'(acc), 32'h6);

    // Reset while a command executes and another is queued
    cmd_valid   = 1'b1;
    cmd_a       = 4'h1;
    cmd_b       = 4'h2;
    cmd_mod     = ALU_ADD;
    cmd_use_acc = 1'b0;
    @(posedge clk);
    #1;
    cmd_a = 4'h3;
    cmd_b = 4'h3;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("mid_alu_a", 32'(alu_a), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_alu", 32'({alu_a, alu_b, alu_mod}), 32'd0);
    check("mid_rst_acc", 32'(acc), 32'd0);
    check("mid_rst_res", 32'({res_data, res_zero, res_c, res_ovf}), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw_res = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk);
      #1;
      if (res_valid) saw_res = 1'b1;
    end
    check("mid_no_result", 32'(saw_res), 32'd0);
    check("mid_alu_idle", 32'({alu_a, alu_b}), 32'd0);

    // Random traffic against the scoreboard
    model_acc  = '0;
    prev_stall = 1'b0;
    prev_res   = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cmd_valid   = ($urandom_range(0, 99) < 60);
      cmd_a       = 4'($urandom);
      cmd_b       = 4'($urandom);
      cmd_use_acc = 1'($urandom);
      r           = int'($urandom_range(0, 9));
      cmd_mod     = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      res_ready   = ($urandom_range(0, 99) < 50);
      score_step();
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      score_step();
      @(posedge clk);
      #1;
    end
    check("rnd_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
